// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register so frames can run back-to-back.
// tx is registered from the next-state values so the line changes on the same edge as the FSM.
`timescale 1ns / 1ps

module uart_tx #(
  parameter int unsigned baud_rate       = 115200,
  parameter int unsigned clock_frequency = 100000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned ClkPerBit = clock_frequency / baud_rate;
  localparam logic [15:0] BitLast   = 16'(ClkPerBit - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q;
  logic        hold_full_q;
  logic        tx_q, tx_d;
  logic        load;
  logic        accept;
  logic        bit_end;

  assign bit_end = (timer_q == BitLast);
  assign ready_o = ~hold_full_q;
  assign accept  = valid_i & ~hold_full_q;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Accept and load are mutually exclusive: accept needs the holder empty, load needs it full.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_full_q <= 1'b0;
      hold_q      <= '0;
    end else if (load) begin
      hold_full_q <= 1'b0;
    end else if (accept) begin
      hold_full_q <= 1'b1;
      hold_q      <= data_i;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    timer_d = bit_end ? '0 : timer_q + 16'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (hold_full_q) begin
          load    = 1'b1;
          shift_d = hold_q;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          if (hold_full_q) begin
            load    = 1'b1;
            shift_d = hold_q;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StIdle:  tx_d = 1'b1;
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[idx_d];
      StStop:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    busy_o = (state_q != StIdle);
    done_o = (state_q == StStop) && bit_end;
  end

  assign tx_o = tx_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001 Parameter baud_rate, default 115200: serial bit rate in bits/s.
- REQ-002 Parameter clock_frequency, default 100000000: clk frequency in Hz.
- REQ-003 Derived constant clk_per_bit = clock_frequency / baud_rate (integer division); legal range 2..65536, held in a 16-bit bit-timer.
- REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
- REQ-005 Port rst, input, 1: reset; asynchronous and active-high.
- REQ-006 Port data, input, 8: byte to transmit; sampled only on an accepting edge.
- REQ-007 Port valid, input, 1: data holds a byte to send.
- REQ-008 Port ready, output, 1: holding register empty; the byte can be accepted.
- REQ-009 Port tx, output, 1: serial line; idle high; registered.
- REQ-010 Port busy, output, 1: a frame is being shifted out.
- REQ-011 Port done, output, 1: one-cycle pulse at the end of each completed frame.

Function
- REQ-012 Frame format SHALL be 8N1: one start bit (0), data[0] first through data[7], then one stop bit (1); no parity.
- REQ-013 Each bit SHALL be driven on tx for exactly clk_per_bit clk cycles; a full frame is 10*clk_per_bit cycles.
- REQ-014 Handshake: a byte is accepted on a rising edge where valid=1 and ready=1; data is copied into a one-entry holding register and hold_full is set.
- REQ-015 ready SHALL equal NOT hold_full, combinationally; valid while ready=0 is ignored, and no byte is dropped or overwritten.
- REQ-016 FSM states: IDLE, START, DATA, STOP; busy=1 in every state except IDLE.
- REQ-017 IDLE: tx=1; if hold_full=1, move the holding byte to the shift register, clear hold_full, clear the bit-timer, and go to START.
- REQ-018 START: tx=0 for clk_per_bit cycles, then go to DATA with bit index 0.
- REQ-019 DATA: tx = shift register bit [index]; after clk_per_bit cycles, increment the index; after bit 7, go to STOP.
- REQ-020 STOP: tx=1 for clk_per_bit cycles; on the final cycle, assert done for exactly one cycle.
- REQ-021 At the end of STOP with hold_full=1, go directly to START and load the holding byte (back-to-back frames, zero idle cycles); otherwise go to IDLE.
- REQ-022 Latency: tx SHALL fall on the first rising edge after the accepting edge when the FSM is in IDLE.
- REQ-023 A byte may be accepted during any state, including the cycle done is asserted; only one byte is buffered beyond the active frame.
- REQ-024 When hold_full is cleared on the load edge, ready SHALL rise in the following cycle; acceptance and load never occur on the same edge.
- REQ-025 The bit-timer SHALL count 0..clk_per_bit-1 and wrap to 0 at every bit boundary; it never exceeds clk_per_bit-1.

Reset
- REQ-026 While rst=1, asynchronously: state=IDLE, tx=1, busy=0, done=0, hold_full=0 (ready=1), bit-timer=0, bit index=0, shift register=0.
- REQ-027 rst asserted mid-frame SHALL abort the frame; tx returns high immediately, and the holding byte is discarded.
- REQ-028 After rst deasserts, the block SHALL accept a byte on the first clock edge.

Verification (use clock_frequency=1000000, baud_rate=100000, so clk_per_bit=10)
- REQ-029 Single byte 0xA5 accepted in idle -> tx: 10 cycles at 0, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then 10 cycles at 1; one done pulse at cycle 100; busy=0 afterwards.
- REQ-030 0x3C accepted, then 0xC3 offered while busy -> 0xC3 is accepted immediately (ready=1), and ready stays 0 until the second frame loads; the second start bit follows the first stop bit with no gap; 200 cycles total; two done pulses.
- REQ-031 Three bytes offered continuously with valid=1 -> the third byte is stalled (ready=0) until the first frame ends; all three frames are serialized in order with no loss.
- REQ-032 rst pulsed at cycle 45 of a 0xFF frame with a byte buffered -> tx=1, busy=0, ready=1 immediately; no done pulse; the buffered byte is never sent.
- REQ-033 valid=0 and no traffic for 1000 cycles -> tx=1, busy=0, done=0 throughout.
- REQ-034 Bytes 0x00 and 0xFF -> 9-bit low run, then high (0x00); 1-bit low start, then 9 cycles*10 high (0xFF); bit widths are exactly 10 cycles.
